// File: rtl/wd_service_sequencer.sv
// Watchdog service sequencer: closed/open window timing, service pulse generation,
// fault tracking with saturating consecutive-fault count and sticky lockout.
module wd_service_sequencer #(
    parameter int T_CLOSED = 100,
    parameter int T_OPEN   = 50,
    parameter int T_PULSE  = 4,
    parameter int MAX_FAIL = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       KICK,
    input  logic       SWSTAT,
    input  logic       WDFAIL,
    input  logic [1:0] FLSTAT,
    output logic       WDSRVC,
    output logic       FWOVR,
    output logic [2:0] STATE,
    output logic [2:0] FAULT_CODE,
    output logic [3:0] FAILCNT,
    output logic       LOCKOUT,
    output logic       KICK_REJ
);

    localparam int T_MAX_CO = (T_CLOSED > T_OPEN) ? T_CLOSED : T_OPEN;
    localparam int T_MAX    = (T_MAX_CO > T_PULSE + 2) ? T_MAX_CO : T_PULSE + 2;
    localparam int TW       = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0] CLOSED_LAST = TW'(T_CLOSED - 1);
    localparam logic [TW-1:0] OPEN_LAST   = TW'(T_OPEN - 1);
    localparam logic [TW-1:0] PULSE_END   = TW'(T_PULSE);
    localparam logic [TW-1:0] SAMPLE_AT   = TW'(T_PULSE + 2);
    localparam logic [3:0]    FAIL_LIMIT  = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLOSED  = 3'd1,
        S_OPEN    = 3'd2,
        S_SERVICE = 3'd3,
        S_FAULT   = 3'd4,
        S_LOCK    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wdsrvc_q, wdsrvc_d;
    logic          fwovr_q, fwovr_d;
    logic          kick_rej_q, kick_rej_d;
    logic          lockout_q, lockout_d;
    logic [2:0]    fault_code_q, fault_code_d;
    logic [3:0]    failcnt_q, failcnt_d;
    logic          stop_q, stop_d;
    logic          fault_entry;

    // Detector flag and its code travel through the same two-stage synchroniser.
    logic       wdfail_meta_q, wdfail_sync_q;
    logic [1:0] flstat_meta_q, flstat_sync_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d      = state_q;
        fault_code_d = fault_code_q;
        failcnt_d    = failcnt_q;
        stop_d       = stop_q;
        fwovr_d      = 1'b0;
        kick_rej_d   = 1'b0;
        fault_entry  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (EN) state_d = S_CLOSED;
            end
            S_CLOSED: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end else if (KICK) begin
                    state_d      = S_FAULT;
                    fault_code_d = 3'b001;
                    fault_entry  = 1'b1;
                end else if (timer_q == CLOSED_LAST) begin
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end else if (KICK && SWSTAT) begin
                    state_d = S_SERVICE;
                    stop_d  = 1'b0;
                end else begin
                    kick_rej_d = KICK;
                    if (timer_q == OPEN_LAST) begin
                        state_d      = S_FAULT;
                        fault_code_d = 3'b010;
                        fwovr_d      = 1'b1;
                        fault_entry  = 1'b1;
                    end
                end
            end
            S_SERVICE: begin
                // A disable during the pulse is remembered and honoured after the sample.
                if (!EN) stop_d = 1'b1;
                if (timer_q == SAMPLE_AT) begin
                    if (wdfail_sync_q) begin
                        state_d      = S_FAULT;
                        fault_code_d = {1'b1, flstat_sync_q};
                        fault_entry  = 1'b1;
                    end else begin
                        failcnt_d = 4'd0;
                        state_d   = (stop_q || !EN) ? S_IDLE : S_CLOSED;
                    end
                end
            end
            S_FAULT: begin
                if (failcnt_q == FAIL_LIMIT) state_d = S_LOCK;
                else if (EN)                 state_d = S_CLOSED;
                else                         state_d = S_IDLE;
            end
            S_LOCK: begin
                state_d = S_LOCK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fault_entry && (failcnt_q != FAIL_LIMIT)) failcnt_d = failcnt_q + 4'd1;

        // The timer restarts on every state change and only runs in the timed states.
        if ((state_d != state_q) || !(state_q inside {S_CLOSED, S_OPEN, S_SERVICE}))
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;

        wdsrvc_d  = (state_d == S_SERVICE) && (timer_d < PULSE_END);
        lockout_d = lockout_q || (state_d == S_LOCK);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            wdsrvc_q      <= 1'b0;
            fwovr_q       <= 1'b0;
            kick_rej_q    <= 1'b0;
            lockout_q     <= 1'b0;
            fault_code_q  <= 3'b000;
            failcnt_q     <= 4'd0;
            stop_q        <= 1'b0;
            wdfail_meta_q <= 1'b0;
            wdfail_sync_q <= 1'b0;
            flstat_meta_q <= 2'b00;
            flstat_sync_q <= 2'b00;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wdsrvc_q      <= wdsrvc_d;
            fwovr_q       <= fwovr_d;
            kick_rej_q    <= kick_rej_d;
            lockout_q     <= lockout_d;
            fault_code_q  <= fault_code_d;
            failcnt_q     <= failcnt_d;
            stop_q        <= stop_d;
            wdfail_meta_q <= WDFAIL;
            wdfail_sync_q <= wdfail_meta_q;
            flstat_meta_q <= FLSTAT;
            flstat_sync_q <= flstat_meta_q;
        end
    end

    assign STATE      = state_q;
    assign WDSRVC     = wdsrvc_q;
    assign FWOVR      = fwovr_q;
    assign KICK_REJ   = kick_rej_q;
    assign LOCKOUT    = lockout_q;
    assign FAULT_CODE = fault_code_q;
    assign FAILCNT    = failcnt_q;

endmodule

// File: tb/tb_wd_service_sequencer.sv
// Self-checking bench for wd_service_sequencer at default parameters:
// a table of held-input/expected-output records plus directed multi-cycle sequences.
module tb_wd_service_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       EN, KICK, SWSTAT, WDFAIL;
    logic [1:0] FLSTAT;
    logic       WDSRVC, FWOVR, LOCKOUT, KICK_REJ;
    logic [2:0] STATE, FAULT_CODE;
    logic [3:0] FAILCNT;

    int checks   = 0;
    int failures = 0;

    wd_service_sequencer dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .KICK       (KICK),
        .SWSTAT     (SWSTAT),
        .WDFAIL     (WDFAIL),
        .FLSTAT     (FLSTAT),
        .WDSRVC     (WDSRVC),
        .FWOVR      (FWOVR),
        .STATE      (STATE),
        .FAULT_CODE (FAULT_CODE),
        .FAILCNT    (FAILCNT),
        .LOCKOUT    (LOCKOUT),
        .KICK_REJ   (KICK_REJ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One record: inputs held for 'cycles' edges (KICK only on the first), then outputs compared.
    typedef struct {
        logic       en, kick, swstat, wdfail;
        logic [1:0] flstat;
        int         cycles;
        logic [2:0] st;
        logic       ws, fo, kr;
        logic [2:0] fc;
        logic [3:0] cnt;
        logic       lo;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic en, input logic kick, input logic swstat,
                                input int cycles, input logic [2:0] st, input logic ws,
                                input logic fo, input logic kr, input logic [2:0] fc,
                                input logic [3:0] cnt, input logic lo);
        vec_t v;
        v.en = en; v.kick = kick; v.swstat = swstat; v.wdfail = 1'b0; v.flstat = 2'b00;
        v.cycles = cycles; v.st = st; v.ws = ws; v.fo = fo; v.kr = kr;
        v.fc = fc; v.cnt = cnt; v.lo = lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic ws,
                             input logic fo, input logic kr, input logic [2:0] fc,
                             input logic [3:0] cnt, input logic lo);
        check({tag, " STATE"},      8'(STATE),      8'(st));
        check({tag, " WDSRVC"},     8'(WDSRVC),     8'(ws));
        check({tag, " FWOVR"},      8'(FWOVR),      8'(fo));
        check({tag, " KICK_REJ"},   8'(KICK_REJ),   8'(kr));
        check({tag, " FAULT_CODE"}, 8'(FAULT_CODE), 8'(fc));
        check({tag, " FAILCNT"},    8'(FAILCNT),    8'(cnt));
        check({tag, " LOCKOUT"},    8'(LOCKOUT),    8'(lo));
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        EN = v.en; SWSTAT = v.swstat; WDFAIL = v.wdfail; FLSTAT = v.flstat;
        KICK = v.kick;
        tick(1);
        KICK = 1'b0;
        if (v.cycles > 1) tick(v.cycles - 1);
        check_all($sformatf("vec%0d", idx), v.st, v.ws, v.fo, v.kr, v.fc, v.cnt, v.lo);
    endtask

    // Asserts reset away from the clock edge and confirms the asynchronous clear.
    task automatic pulse_reset(input string tag);
        #2;
        RST_N = 1'b0;
        #1;
        check_all(tag, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        tick(2);
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; KICK = 1'b0; SWSTAT = 1'b1; WDFAIL = 1'b0; FLSTAT = 2'b00;

        //            en kick sw  cyc  st   ws fo kr fc    cnt  lo
        vecs[0]  = mk(1, 0, 1,   1,   3'd1, 0, 0, 0, 3'd0, 4'd0, 0); // CLOSED entry
        vecs[1]  = mk(1, 0, 1,   110, 3'd2, 0, 0, 0, 3'd0, 4'd0, 0); // OPEN timer 10
        vecs[2]  = mk(1, 1, 1,   1,   3'd3, 1, 0, 0, 3'd0, 4'd0, 0); // accepted kick
        vecs[3]  = mk(1, 0, 1,   3,   3'd3, 1, 0, 0, 3'd0, 4'd0, 0); // pulse cycle 3
        vecs[4]  = mk(1, 0, 1,   1,   3'd3, 0, 0, 0, 3'd0, 4'd0, 0); // pulse ended
        vecs[5]  = mk(1, 0, 1,   3,   3'd1, 0, 0, 0, 3'd0, 4'd0, 0); // back to CLOSED
        vecs[6]  = mk(1, 0, 1,   50,  3'd1, 0, 0, 0, 3'd0, 4'd0, 0); // CLOSED timer 50
        vecs[7]  = mk(1, 1, 1,   1,   3'd4, 0, 0, 0, 3'd1, 4'd1, 0); // early kick
        vecs[8]  = mk(1, 0, 1,   1,   3'd1, 0, 0, 0, 3'd1, 4'd1, 0); // FAULT one cycle
        vecs[9]  = mk(1, 0, 1,   149, 3'd2, 0, 0, 0, 3'd1, 4'd1, 0); // OPEN last cycle
        vecs[10] = mk(1, 0, 1,   1,   3'd4, 0, 1, 0, 3'd2, 4'd2, 0); // timeout at +150
        vecs[11] = mk(1, 0, 1,   1,   3'd1, 0, 0, 0, 3'd2, 4'd2, 0); // FWOVR one cycle
        vecs[12] = mk(1, 0, 1,   105, 3'd2, 0, 0, 0, 3'd2, 4'd2, 0); // OPEN timer 5
        vecs[13] = mk(1, 1, 0,   1,   3'd2, 0, 0, 1, 3'd2, 4'd2, 0); // rejected kick
        vecs[14] = mk(1, 0, 1,   1,   3'd2, 0, 0, 0, 3'd2, 4'd2, 0); // reject one cycle
        vecs[15] = mk(1, 0, 1,   42,  3'd2, 0, 0, 0, 3'd2, 4'd2, 0); // timer not cleared
        vecs[16] = mk(1, 0, 1,   1,   3'd4, 0, 1, 0, 3'd2, 4'd3, 0); // third fault
        vecs[17] = mk(1, 0, 1,   1,   3'd5, 0, 0, 0, 3'd2, 4'd3, 1); // lockout
        vecs[18] = mk(1, 1, 1,   1,   3'd5, 0, 0, 0, 3'd2, 4'd3, 1); // kick ignored
        vecs[19] = mk(1, 1, 0,   3,   3'd5, 0, 0, 0, 3'd2, 4'd3, 1); // no reject in LOCK

        tick(2);
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
        RST_N = 1'b1;
        tick(1);
        check("idle with EN=0", 8'(STATE), 8'd0);

        for (int i = 0; i < 20; i++) apply_vec(vecs[i], i);

        // Three consecutive window timeouts from a fresh start lead to lockout.
        pulse_reset("reset from lock");
        EN = 1'b1; SWSTAT = 1'b1; WDFAIL = 1'b0;
        tick(1);
        check("lock seq CLOSED entry", 8'(STATE), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick(149);
            check($sformatf("timeout%0d pre FWOVR", i), 8'(FWOVR), 8'd0);
            tick(1);
            check_all($sformatf("timeout%0d", i), 3'd4, 1'b0, 1'b1, 1'b0, 3'd2, 4'(i + 1), 1'b0);
            tick(1);
            check($sformatf("timeout%0d FWOVR drop", i), 8'(FWOVR), 8'd0);
        end
        check_all("locked", 3'd5, 1'b0, 1'b0, 1'b0, 3'd2, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            KICK = 1'b1;
            tick(1);
            KICK = 1'b0;
            tick(1);
        end
        check_all("locked after kicks", 3'd5, 1'b0, 1'b0, 1'b0, 3'd2, 4'd3, 1'b1);
        pulse_reset("reset clears lock");

        // Detector fail reported during SERVICE.
        WDFAIL = 1'b1; FLSTAT = 2'b10; EN = 1'b1; SWSTAT = 1'b1;
        tick(111);
        check("fail seq OPEN", 8'(STATE), 8'd2);
        KICK = 1'b1;
        tick(1);
        KICK = 1'b0;
        check("fail seq SERVICE", 8'(STATE), 8'd3);
        tick(7);
        check_all("detector fail", 3'd4, 1'b0, 1'b0, 1'b0, 3'd6, 4'd1, 1'b0);
        tick(1);
        check("detector fail exit", 8'(STATE), 8'd1);

        // Reset in the middle of the service pulse.
        tick(100);
        KICK = 1'b1;
        tick(1);
        KICK = 1'b0;
        tick(1);
        check("mid pulse WDSRVC", 8'(WDSRVC), 8'd1);
        pulse_reset("reset mid pulse");
        check("first state after release", 8'(STATE), 8'd0);
        tick(1);
        check("CLOSED after release", 8'(STATE), 8'd1);

        // EN dropped during SERVICE: sample completes, then IDLE; healthy sample clears FAILCNT.
        WDFAIL = 1'b0;
        tick(100);
        KICK = 1'b1;
        tick(1);
        KICK = 1'b0;
        EN = 1'b0;
        tick(6);
        check("EN drop still SERVICE", 8'(STATE), 8'd3);
        tick(1);
        check_all("EN drop to IDLE", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
